// File: rtl/food_ctrl.sv
// -----------------------------------------------------------------------------
// food_ctrl
//   Places food for the snake datapath and raises the eat pulse.
//   A free-running 16-bit LFSR supplies candidate cells. Each candidate is
//   checked against one complete body scan that starts after placement. A
//   candidate on the body is dropped and a new one drawn. A clean candidate
//   becomes visible food. The food is eaten when the head lands on it at
//   tick completion.
//
//   Stream handshake: an element of the body stream counts only in a cycle
//   with i_pos_valid=1. i_pos_first marks the head element and i_pos_last
//   marks the tail. There is no backpressure; this block always accepts.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   i_tick_done           head position is final for this tick
//   i_head_x, i_head_y    current head cell
//   i_pos_x, i_pos_y      body-stream cell
//   i_pos_first/last      stream element is head / tail
//   i_pos_valid           stream element is a real body cell
//   i_success             snake reached maximum length (sticky stop)
//   o_eat                 one-cycle pulse: food eaten
//   o_food_x, o_food_y    food cell (meaningful when o_food_valid=1)
//   o_food_valid          food placed and visible
// -----------------------------------------------------------------------------
module food_ctrl #(
  parameter int          GAME_WIDTH  = 20,
  parameter int          GAME_HEIGHT = 13,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_done,
  input  logic [4:0] i_head_x,
  input  logic [3:0] i_head_y,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_success,
  output logic       o_eat,
  output logic [4:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_food_valid
);

  localparam logic [2:0] S_PLACE  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        hit;
  logic [4:0]  cx;
  logic [3:0]  cy;
  logic [4:0]  cand_x;
  logic [3:0]  cand_y;
  logic        pos_match;
  logic        head_match;

  // Taps 16,14,13,11 in right-shifting form: tap k reads bit (16-k).
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Raw fields never reach twice the board size, so one subtraction wraps.
  always_comb begin
    cx = lfsr[4:0];
    if (cx >= 5'(GAME_WIDTH)) cx = cx - 5'(GAME_WIDTH);
    cy = lfsr[9:6];
    if (cy >= 4'(GAME_HEIGHT)) cy = cy - 4'(GAME_HEIGHT);
    cand_x = cx + 5'd1;
    cand_y = cy + 4'd1;
  end

  assign pos_match  = i_pos_valid && (i_pos_x == o_food_x) && (i_pos_y == o_food_y);
  assign head_match = (i_head_x == o_food_x) && (i_head_y == o_food_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      state        <= S_PLACE;
      hit          <= 1'b0;
      o_eat        <= 1'b0;
      o_food_valid <= 1'b0;
      o_food_x     <= 5'd0;
      o_food_y     <= 4'd0;
    end else begin
      lfsr  <= lfsr_next;
      o_eat <= 1'b0;
      if (i_success) begin
        state        <= S_DONE;
        o_food_valid <= 1'b0;
      end else begin
        case (state)
          S_PLACE: begin
            o_food_x <= cand_x;
            o_food_y <= cand_y;
            hit      <= 1'b0;
            state    <= S_WAIT;
          end
          // Elements before the head belong to a scan that began before this
          // candidate existed, so they are skipped.
          S_WAIT: begin
            if (i_pos_valid && i_pos_first) begin
              if (i_pos_last) begin
                if (pos_match) begin
                  state <= S_PLACE;
                end else begin
                  state        <= S_ACTIVE;
                  o_food_valid <= 1'b1;
                end
              end else begin
                hit   <= pos_match;
                state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (i_pos_valid) begin
              hit <= hit | pos_match;
              if (i_pos_last) begin
                // The tail is folded in directly rather than through hit.
                if (hit || pos_match) begin
                  state <= S_PLACE;
                end else begin
                  state        <= S_ACTIVE;
                  o_food_valid <= 1'b1;
                end
              end
            end
          end
          S_ACTIVE: begin
            if (i_tick_done && head_match) begin
              o_eat        <= 1'b1;
              o_food_valid <= 1'b0;
              state        <= S_PLACE;
            end
          end
          S_DONE: begin
            o_food_valid <= 1'b0;
          end
          default: state <= S_PLACE;
        endcase
      end
    end
  end

endmodule
